// File: rtl/axis_img_frame_gate.sv
// axis_img_frame_gate: frame-aligned gate for a 16-bit AXI-Stream pixel bus.
// Drops data until start of frame, then passes whole frames with length checks.
module axis_img_frame_gate #(
  parameter int IMG_WIDTH  = 384,
  parameter int IMG_HEIGHT = 288
) (
  input  logic        axis_aclk,
  input  logic        axis_areset,
  input  logic        enable,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        frame_done,
  output logic        err_len,
  output logic        err_sof,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(IMG_WIDTH);
  localparam int LW = $clog2(IMG_HEIGHT);
  localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          fd_q, fd_d;
  logic          el_q, el_d;
  logic          es_q, es_d;
  logic          acc;

  // Handshake steering: data path is always a wire, only valid/ready gate.
  always_comb begin
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast;
    m_axis_tuser  = s_axis_tuser;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (s_axis_tuser) begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
        end else begin
          s_axis_tready = 1'b1;
        end
      end
      S_RUN: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
      end
      default: ;
    endcase
  end

  assign acc = s_axis_tvalid & s_axis_tready;

  // State, position tracking and status event generation.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    fcnt_d  = fcnt_q;
    fd_d    = 1'b0;
    el_d    = 1'b0;
    es_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (acc && s_axis_tuser) begin
          state_d = S_RUN;
          pix_d   = s_axis_tlast ? '0 : PW'(1);
          line_d  = s_axis_tlast ? LW'(1) : '0;
        end
      end
      S_RUN: begin
        if (acc) begin
          if (s_axis_tuser && (pix_q != '0 || line_q != '0)) begin
            es_d   = 1'b1;
            pix_d  = s_axis_tlast ? '0 : PW'(1);
            line_d = s_axis_tlast ? LW'(1) : '0;
          end else if (s_axis_tlast) begin
            el_d  = (pix_q != PIX_LAST);
            pix_d = '0;
            if (line_q == LINE_LAST) begin
              line_d = '0;
              fd_d   = 1'b1;
              fcnt_d = fcnt_q + 16'd1;
              if (!enable) state_d = S_IDLE;
            end else begin
              line_d = line_q + LW'(1);
            end
          end else if (pix_q == PIX_LAST) begin
            el_d  = 1'b1;
            pix_d = '0;
          end else begin
            pix_d = pix_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state with synchronous reset.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      fcnt_q  <= '0;
      fd_q    <= 1'b0;
      el_q    <= 1'b0;
      es_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      fcnt_q  <= fcnt_d;
      fd_q    <= fd_d;
      el_q    <= el_d;
      es_q    <= es_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = fd_q;
  assign err_len    = el_q;
  assign err_sof    = es_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_axis_img_frame_gate.sv
// tb_axis_img_frame_gate: scoreboard bench for the frame gate.
// Runs with a 4x2 image so whole frames stay short.
module tb_axis_img_frame_gate;

  logic        clk = 1'b0;
  logic        areset;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid, s_ready, s_last, s_user;
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_last, m_user;
  logic        busy, frame_done, err_len, err_sof;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int fd_n  = 0;
  int el_n  = 0;
  int es_n  = 0;

  always #5 clk = ~clk;

  axis_img_frame_gate #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .axis_aclk    (clk),
    .axis_areset  (areset),
    .enable       (enable),
    .s_axis_tdata (s_data),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast (s_last),
    .s_axis_tuser (s_user),
    .m_axis_tdata (m_data),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_last),
    .m_axis_tuser (m_user),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_len      (err_len),
    .err_sof      (err_sof),
    .frame_cnt    (frame_cnt)
  );

  task automatic cycle(output bit acc);
    beat_t e;
    beat_t got;
    #1;
    if (m_valid && m_ready) begin
      got = {m_data, m_last, m_user};
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got %h, required no beat", got);
      end else begin
        e = expq.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL sb_beat: got %h, required %h", got, e);
        end
      end
    end
    acc = s_valid && s_ready;
    @(posedge clk);
    @(negedge clk);
    fd_n += int'(frame_done);
    el_n += int'(err_len);
    es_n += int'(err_sof);
  endtask

  task automatic idle(input int n);
    bit a;
    s_valid = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic u,
                      input bit pass, input bit rnd);
    bit a;
    int t;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        m_ready = 1'($urandom_range(0, 1));
        cycle(a);
      end
    end
    s_data  = d;
    s_last  = l;
    s_user  = u;
    s_valid = 1'b1;
    if (pass) expq.push_back({d, l, u});
    t = 0;
    a = 1'b0;
    while (!a && t < 64) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(a);
      t++;
    end
    s_valid = 1'b0;
    if (!a) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: beat %h not accepted, required accept", d);
    end
  endtask

  task automatic send_frame(input logic [15:0] base, input bit rnd,
                            input int drop_at);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) enable = 1'b0;
      send(16'(base + i), i == 3 || i == 7, i == 0, 1'b1, rnd);
    end
  endtask

  task automatic test_reset;
    areset  = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_user  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    idle(3);
    s_valid = 1'b1;
    #1;
    n_cmp++;
    if ({s_ready, m_valid, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_hs: rdy/vld/busy=%b required 000", {s_ready, m_valid, busy});
    end
    n_cmp++;
    if ({frame_done, err_len, err_sof, frame_cnt} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_stat: cnt=%h pulses=%b required 0", frame_cnt,
               {frame_done, err_len, err_sof});
    end
    areset = 1'b0;
    idle(2);
    n_cmp++;
    if ({s_ready, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL post_reset: rdy/busy=%b required 00", {s_ready, busy});
    end
  endtask

  task automatic test_basic;
    int fd0 = fd_n;
    enable = 1'b1;
    for (int i = 0; i < 3; i++)
      send(16'(16'hDE00 + i), i == 1, 1'b0, 1'b0, 1'b0);
    send_frame(16'h0010, 1'b0, -1);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_done: fd=%b cnt=%0d required 1/1", frame_done, frame_cnt);
    end
    idle(1);
    n_cmp++;
    if (frame_done !== 1'b0 || fd_n - fd0 !== 1) begin
      n_bad++;
      $display("FAIL basic_pulse: fd=%b n=%0d required 0/1", frame_done, fd_n - fd0);
    end
    n_cmp++;
    if (el_n + es_n !== 0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_err: errs=%0d busy=%b required 0/1", el_n + es_n, busy);
    end
  endtask

  task automatic test_enable_drop;
    int fd0 = fd_n;
    send_frame(16'h0100, 1'b0, 2);
    n_cmp++;
    if (fd_n - fd0 !== 1 || frame_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL drop_done: n=%0d cnt=%0d required 1/2", fd_n - fd0, frame_cnt);
    end
    s_valid = 1'b1;
    s_user  = 1'b1;
    #1;
    n_cmp++;
    if ({busy, s_ready, m_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL drop_idle: busy/rdy/vld=%b required 000", {busy, s_ready, m_valid});
    end
    idle(2);
  endtask

  task automatic test_len_err;
    int fd0 = fd_n;
    int el0 = el_n;
    enable = 1'b1;
    send(16'h0200, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h0201, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h0202, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (err_len !== 1'b1 || fd_n - fd0 !== 0) begin
      n_bad++;
      $display("FAIL len_pulse: el=%b fd=%0d required 1/0", err_len, fd_n - fd0);
    end
    for (int i = 0; i < 4; i++)
      send(16'(16'h0203 + i), i == 3, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (el_n - el0 !== 1 || fd_n - fd0 !== 1 || frame_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL len_frame: el=%0d fd=%0d cnt=%0d required 1/1/3",
               el_n - el0, fd_n - fd0, frame_cnt);
    end
  endtask

  task automatic test_sof_err;
    int fd0 = fd_n;
    int es0 = es_n;
    int el0 = el_n;
    for (int i = 0; i < 5; i++)
      send(16'(16'h0300 + i), i == 3, i == 0, 1'b1, 1'b0);
    send(16'h0400, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (err_sof !== 1'b1 || fd_n - fd0 !== 0) begin
      n_bad++;
      $display("FAIL sof_pulse: es=%b fd=%0d required 1/0", err_sof, fd_n - fd0);
    end
    for (int i = 1; i < 8; i++)
      send(16'(16'h0400 + i), i == 3 || i == 7, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (es_n - es0 !== 1 || el_n - el0 !== 0 || fd_n - fd0 !== 1 ||
        frame_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL sof_frame: es=%0d el=%0d fd=%0d cnt=%0d required 1/0/1/4",
               es_n - es0, el_n - el0, fd_n - fd0, frame_cnt);
    end
  endtask

  task automatic test_random;
    int fd0 = fd_n;
    int er0 = el_n + es_n;
    for (int f = 0; f < 10; f++)
      send_frame(16'(16'h1000 + f * 16), 1'b1, -1);
    m_ready = 1'b1;
    n_cmp++;
    if (fd_n - fd0 !== 10 || frame_cnt !== 16'd14 || el_n + es_n - er0 !== 0) begin
      n_bad++;
      $display("FAIL rand_frames: fd=%0d cnt=%0d errs=%0d required 10/14/0",
               fd_n - fd0, frame_cnt, el_n + es_n - er0);
    end
    n_cmp++;
    if (expq.size() !== 0) begin
      n_bad++;
      $display("FAIL rand_sb: %0d beats missing, required 0", expq.size());
    end
  endtask

  task automatic test_wrap_reset;
    int fd0;
    int p0;
    force dut.fcnt_q = 16'hFFFF;
    #1;
    release dut.fcnt_q;
    #1;
    n_cmp++;
    if (frame_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_preload: cnt=%h required ffff", frame_cnt);
    end
    fd0 = fd_n;
    send_frame(16'h2000, 1'b0, -1);
    n_cmp++;
    if (frame_cnt !== 16'h0000 || fd_n - fd0 !== 1) begin
      n_bad++;
      $display("FAIL wrap_cnt: cnt=%h fd=%0d required 0000/1", frame_cnt, fd_n - fd0);
    end
    for (int i = 0; i < 3; i++)
      send(16'(16'h3000 + i), 1'b0, i == 0, 1'b1, 1'b0);
    p0 = fd_n + el_n + es_n;
    areset = 1'b1;
    idle(1);
    s_valid = 1'b1;
    s_user  = 1'b1;
    #1;
    n_cmp++;
    if ({busy, s_ready, m_valid} !== 3'b000 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid: busy/rdy/vld=%b cnt=%h required 000/0000",
               {busy, s_ready, m_valid}, frame_cnt);
    end
    areset = 1'b0;
    idle(2);
    n_cmp++;
    if (fd_n + el_n + es_n !== p0) begin
      n_bad++;
      $display("FAIL rst_pulse: %0d pulses, required 0", fd_n + el_n + es_n - p0);
    end
    fd0 = fd_n;
    send_frame(16'h4000, 1'b0, -1);
    n_cmp++;
    if (frame_cnt !== 16'd1 || fd_n - fd0 !== 1 || expq.size() !== 0) begin
      n_bad++;
      $display("FAIL rst_resume: cnt=%0d fd=%0d sb=%0d required 1/1/0",
               frame_cnt, fd_n - fd0, expq.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_enable_drop;
    test_len_err;
    test_sof_err;
    test_random;
    test_wrap_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
